// File: rtl/shift_chain_receiver_if.sv
// Link-side signal bundle for the shift-chain receiver.
// The master modport drives the serial link and observes the decoded frame.
// The slave modport is the receiver itself.
interface shift_chain_receiver_if #(
    parameter int N_CHANNELS = 16,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 16
);
    // Asynchronous serial link inputs
    logic [N_CHANNELS-1:0]       i_channel;
    logic                        i_data_clk;
    logic                        i_latch;
    logic                        i_sync;

    // Decoded frame and status
    logic [N_CHANNELS*DEPTH-1:0] o_frame;
    logic                        o_valid;
    logic                        o_len_error;
    logic [CNT_W-1:0]            o_bit_count;
    logic [CNT_W-1:0]            o_frame_count;
    logic                        o_sync_pulse;
    logic                        o_aligned;

    modport master (
        output i_channel, i_data_clk, i_latch, i_sync,
        input  o_frame, o_valid, o_len_error, o_bit_count,
               o_frame_count, o_sync_pulse, o_aligned
    );

    modport slave (
        input  i_channel, i_data_clk, i_latch, i_sync,
        output o_frame, o_valid, o_len_error, o_bit_count,
               o_frame_count, o_sync_pulse, o_aligned
    );
endinterface

// File: rtl/shift_chain_receiver.sv
// Serial channel link receiver.
// Oversamples the asynchronous link on i_clk, shifts every lane into its own
// DEPTH-bit chain on each data-clock rise, and copies all chains into the
// parallel frame register on each latch rise once the link is aligned.
module shift_chain_receiver #(
    parameter int N_CHANNELS  = 16,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    shift_chain_receiver_if.slave  link
);

    typedef enum logic {
        WAIT_ALIGN,
        ACTIVE
    } state_e;

    // Synchronizer chains; the last stage is the usable, metastability-free copy
    logic [SYNC_STAGES-1:0][N_CHANNELS-1:0] lane_sync_q;
    logic [SYNC_STAGES-1:0]                 dclk_sync_q;
    logic [SYNC_STAGES-1:0]                 latch_sync_q;
    logic [SYNC_STAGES-1:0]                 sync_sync_q;

    // One extra delayed copy for rising-edge detection
    logic dclk_prev_q;
    logic latch_prev_q;
    logic sync_prev_q;

    logic [N_CHANNELS-1:0] lane_s;
    logic                  dclk_rise;
    logic                  latch_rise;
    logic                  sync_rise;

    // Per-lane shift chains
    logic [N_CHANNELS-1:0][DEPTH-1:0] chain_q;
    logic [N_CHANNELS-1:0][DEPTH-1:0] chain_d;

    // Framing state and registered outputs
    state_e                      state_q;
    logic [N_CHANNELS*DEPTH-1:0] frame_q;
    logic                        valid_q;
    logic                        len_error_q;
    logic [CNT_W-1:0]            bit_count_q;
    logic [CNT_W-1:0]            bit_count_d;
    logic [CNT_W-1:0]            frame_count_q;
    logic                        sync_pulse_q;
    logic                        aligned_q;

    // Bring every link input into the i_clk domain and keep the previous sample
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lane_sync_q  <= '0;
            dclk_sync_q  <= '0;
            latch_sync_q <= '0;
            sync_sync_q  <= '0;
            dclk_prev_q  <= 1'b0;
            latch_prev_q <= 1'b0;
            sync_prev_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the old value
            // of its predecessor, which is what makes this a shift register.
            lane_sync_q  <= {lane_sync_q[SYNC_STAGES-2:0], link.i_channel};
            dclk_sync_q  <= {dclk_sync_q[SYNC_STAGES-2:0], link.i_data_clk};
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], link.i_latch};
            sync_sync_q  <= {sync_sync_q[SYNC_STAGES-2:0], link.i_sync};
            dclk_prev_q  <= dclk_sync_q[SYNC_STAGES-1];
            latch_prev_q <= latch_sync_q[SYNC_STAGES-1];
            sync_prev_q  <= sync_sync_q[SYNC_STAGES-1];
        end
    end

    // Lanes come from the same stage as the data clock so their skew matches
    assign lane_s     = lane_sync_q[SYNC_STAGES-1];
    assign dclk_rise  = dclk_sync_q[SYNC_STAGES-1]  & ~dclk_prev_q;
    assign latch_rise = latch_sync_q[SYNC_STAGES-1] & ~latch_prev_q;
    assign sync_rise  = sync_sync_q[SYNC_STAGES-1]  & ~sync_prev_q;

    // Next chain value: newest bit enters at the LSB, oldest falls off the MSB
    for (genvar k = 0; k < N_CHANNELS; k++) begin : g_lane
        assign chain_d[k] = dclk_rise ? {chain_q[k][DEPTH-2:0], lane_s[k]} : chain_q[k];
    end

    // Shift chains advance on every data-clock rise regardless of framing state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the chains are reset because a short first frame after reset
            // exposes older chain bits in o_frame; they must be a known zero.
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    // Bit count including a shift in this cycle, saturating at all-ones
    assign bit_count_d = (dclk_rise && bit_count_q != '1) ? bit_count_q + CNT_W'(1)
                                                          : bit_count_q;

    // Framing FSM: first latch aligns, later latches publish the chains
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= WAIT_ALIGN;
            frame_q       <= '0;
            valid_q       <= 1'b0;
            len_error_q   <= 1'b0;
            bit_count_q   <= '0;
            frame_count_q <= '0;
            sync_pulse_q  <= 1'b0;
            aligned_q     <= 1'b0;
        end else begin
            valid_q      <= 1'b0;
            sync_pulse_q <= sync_rise;
            bit_count_q  <= bit_count_d;
            if (latch_rise) begin
                // A shift in the same cycle is already folded into chain_d and
                // bit_count_d, so the frame and the length check include it.
                bit_count_q <= '0;
                unique case (state_q)
                    WAIT_ALIGN: begin
                        state_q   <= ACTIVE;
                        aligned_q <= 1'b1;
                    end
                    ACTIVE: begin
                        frame_q       <= chain_d;
                        valid_q       <= 1'b1;
                        frame_count_q <= frame_count_q + CNT_W'(1);
                        if (bit_count_d != CNT_W'(DEPTH)) begin
                            len_error_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign link.o_frame       = frame_q;
    assign link.o_valid       = valid_q;
    assign link.o_len_error   = len_error_q;
    assign link.o_bit_count   = bit_count_q;
    assign link.o_frame_count = frame_count_q;
    assign link.o_sync_pulse  = sync_pulse_q;
    assign link.o_aligned     = aligned_q;

endmodule

// File: tb/tb_shift_chain_receiver.sv
// Self-checking bench for shift_chain_receiver.
// Drives the serial link slowly (8 i_clk cycles per event) and compares the
// receiver against a reference built from the bit history of each lane.
module tb_shift_chain_receiver;

    localparam int N  = 16;
    localparam int D  = 8;
    localparam int S  = 2;
    localparam int W  = 16;
    localparam int FW = N * D;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    shift_chain_receiver_if #(.N_CHANNELS(N), .DEPTH(D), .CNT_W(W)) link ();

    shift_chain_receiver #(
        .N_CHANNELS (N),
        .DEPTH      (D),
        .SYNC_STAGES(S),
        .CNT_W      (W)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .link   (link)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: lane words in shift order, newest at the back
    logic [N-1:0]  hist[$];
    int            m_count;
    bit            m_aligned;
    int            m_frames;
    bit            m_err;
    logic [FW-1:0] m_frame;

    // Results of the last link event
    int valid_n;
    int valid_at;
    int sync_n;

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        m_count   = 0;
        m_aligned = 0;
        m_frames  = 0;
        m_err     = 0;
        m_frame   = '0;
    endfunction

    function automatic void model_shift(input logic [N-1:0] lanes);
        hist.push_back(lanes);
        if (hist.size() > D) void'(hist.pop_front());
        if (m_count < (1 << W) - 1) m_count++;
    endfunction

    // Frame bit i of lane k is the i-th most recent bit shifted on that lane
    function automatic logic [FW-1:0] history_frame();
        logic [FW-1:0] f = '0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < D; i++) begin
                int idx = hist.size() - 1 - i;
                if (idx >= 0) f[k*D + i] = hist[idx][k];
            end
        end
        return f;
    endfunction

    // Returns whether this latch is expected to emit a frame
    function automatic bit model_latch();
        if (!m_aligned) begin
            m_aligned = 1;
            m_count   = 0;
            return 0;
        end
        m_frame  = history_frame();
        m_frames = (m_frames + 1) % (1 << W);
        if (m_count != D) m_err = 1;
        m_count = 0;
        return 1;
    endfunction

    // One link event: set lanes, raise the chosen strobes for 3 cycles, and
    // watch o_valid / o_sync_pulse for a bounded 6-cycle window.
    task automatic link_event(input logic [N-1:0] lanes, input bit dclk,
                              input bit latch, input bit sync);
        link.i_channel = lanes;
        repeat (2) @(negedge clk);
        link.i_data_clk = dclk;
        link.i_latch    = latch;
        link.i_sync     = sync;
        valid_n  = 0;
        valid_at = -1;
        sync_n   = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (link.o_valid === 1'b1) begin
                valid_n++;
                valid_at = c;
            end
            if (link.o_sync_pulse === 1'b1) sync_n++;
            if (c == 3) begin
                link.i_data_clk = 1'b0;
                link.i_latch    = 1'b0;
                link.i_sync     = 1'b0;
            end
        end
    endtask

    task automatic shift(input logic [N-1:0] lanes);
        model_shift(lanes);
        link_event(lanes, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic latch_and_check(input string tag, input bit with_shift, input logic [N-1:0] lanes);
        bit exp_v;
        if (with_shift) model_shift(lanes);
        exp_v = model_latch();
        link_event(lanes, with_shift, 1'b1, 1'b0);
        check({tag, ".valid_n"},  FW'(valid_n),  FW'(exp_v ? 1 : 0));
        check({tag, ".valid_at"}, FW'(valid_at), FW'(exp_v ? S + 1 : -1));
        check({tag, ".frame"},    link.o_frame, m_frame);
        check({tag, ".fcount"},   FW'(link.o_frame_count), FW'(m_frames));
        check({tag, ".len_err"},  FW'(link.o_len_error), FW'(m_err));
        check({tag, ".aligned"},  FW'(link.o_aligned), FW'(m_aligned));
        check({tag, ".bitcnt"},   FW'(link.o_bit_count), FW'(m_count));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst.frame",   link.o_frame, '0);
        check("rst.valid",   FW'(link.o_valid), '0);
        check("rst.len_err", FW'(link.o_len_error), '0);
        check("rst.bitcnt",  FW'(link.o_bit_count), '0);
        check("rst.fcount",  FW'(link.o_frame_count), '0);
        check("rst.sync",    FW'(link.o_sync_pulse), '0);
        check("rst.aligned", FW'(link.o_aligned), '0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [9:0]   lane3_bits;
        logic [7:0]   lane0_bits;
        logic [N-1:0] lanes;

        link.i_channel  = '0;
        link.i_data_clk = 1'b0;
        link.i_latch    = 1'b0;
        link.i_sync     = 1'b0;
        model_reset();

        // Power-on reset
        repeat (3) @(negedge clk);
        pulse_reset();
        repeat (2) @(negedge clk);

        // First latch with no data only aligns
        latch_and_check("align", 1'b0, '0);
        check("align.frame0", link.o_frame, '0);

        // Known 8-bit frame: lane0 = 1,0,1,1,0,0,1,0 ; lane15 all ones
        lane0_bits = 8'b1011_0010;
        for (int b = 0; b < D; b++) shift({1'b1, 14'b0, lane0_bits[7-b]});
        check("f1.bitcnt8", FW'(link.o_bit_count), FW'(8));
        latch_and_check("f1", 1'b0, '0);
        check("f1.const", link.o_frame, 128'hFF00_0000_0000_0000_0000_0000_0000_00B2);

        // 8th data-clock rise coincides with the latch rise
        for (int b = 0; b < D - 1; b++) shift(16'($urandom));
        lanes = 16'($urandom);
        latch_and_check("simul", 1'b1, lanes);

        // Short frame raises the sticky error; a good frame keeps it set
        for (int b = 0; b < 7; b++) shift(16'($urandom));
        latch_and_check("short", 1'b0, '0);
        check("short.err_set", FW'(link.o_len_error), FW'(1));
        for (int b = 0; b < D; b++) shift(16'($urandom));
        latch_and_check("after_short", 1'b0, '0);

        // Long frame on lane3 keeps only the last 8 bits
        lane3_bits = 10'b00_1111_0001;
        for (int b = 0; b < 10; b++) shift(16'(lane3_bits[9-b]) << 3);
        latch_and_check("long", 1'b0, '0);
        check("long.const", FW'(link.o_frame[31:24]), FW'(8'hF1));

        // Reset mid-frame, then realign before frames resume
        for (int b = 0; b < 4; b++) shift(16'($urandom));
        pulse_reset();
        for (int b = 0; b < D; b++) shift(16'($urandom));
        latch_and_check("realign", 1'b0, '0);
        for (int b = 0; b < D; b++) shift(16'($urandom));
        latch_and_check("post_rst", 1'b0, '0);
        check("post_rst.fcount1", FW'(link.o_frame_count), FW'(1));

        // Two sync rises give exactly two pulses and leave framing alone
        link_event('0, 1'b0, 1'b0, 1'b1);
        check("sync1", FW'(sync_n), FW'(1));
        link_event('0, 1'b0, 1'b0, 1'b1);
        check("sync2", FW'(sync_n), FW'(1));
        check("sync.no_valid", FW'(valid_n), FW'(0));
        check("sync.fcount", FW'(link.o_frame_count), FW'(m_frames));

        // Randomized frames of varying length, some with coincident edges
        for (int f = 0; f < 12; f++) begin
            int len;
            bit simul;
            len   = int'($urandom_range(6, 10));
            simul = ($urandom_range(0, 3) == 0);
            for (int b = 0; b < len - int'(simul); b++) shift(16'($urandom));
            lanes = 16'($urandom);
            latch_and_check("rand", simul, lanes);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
